// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial receiver: word widths, length codes,
// the length-code to bit-count conversion and the receive FSM states.
package sti_pkg;

  localparam int unsigned STI_WORD_W = 32;
  localparam int unsigned STI_CNT_W  = 16;
  localparam int unsigned STI_IDX_W  = 5;
  localparam int unsigned STI_LEN_W  = 2;
  localparam int unsigned STI_BITS_W = 6;

  localparam logic [STI_LEN_W-1:0] STI_LEN_8  = 2'b00;
  localparam logic [STI_LEN_W-1:0] STI_LEN_16 = 2'b01;
  localparam logic [STI_LEN_W-1:0] STI_LEN_24 = 2'b10;
  localparam logic [STI_LEN_W-1:0] STI_LEN_32 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } sti_state_e;

  // Number of bits in a frame for a given length code.
  function automatic logic [STI_BITS_W-1:0] sti_len_bits(input logic [STI_LEN_W-1:0] len);
    logic [STI_BITS_W-1:0] bits;
    case (len)
      STI_LEN_8:  bits = 6'd8;
      STI_LEN_16: bits = 6'd16;
      STI_LEN_24: bits = 6'd24;
      STI_LEN_32: bits = 6'd32;
      default:    bits = 6'd8;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/sti_rx_assemble.sv
// Frame assembly for the STI receiver: bit counter plus shift/position register.
// word_c/done_c reflect the frame including the bit sampled this cycle.
module sti_rx_assemble
  import sti_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_i,
  input  logic                  start_i,
  input  logic                  bit_i,
  input  logic [STI_LEN_W-1:0]  len_i,
  input  logic                  msb_i,
  output logic                  done_c,
  output logic [STI_WORD_W-1:0] word_c
);

  logic [STI_IDX_W-1:0]  idx_q, idx_d;
  logic [STI_WORD_W-1:0] sh_q, sh_d;
  logic [STI_LEN_W-1:0]  len_q, len_d;
  logic                  msb_q, msb_d;

  logic [STI_LEN_W-1:0]  len_eff;
  logic                  msb_eff;
  logic [STI_IDX_W-1:0]  idx_eff;
  logic [STI_IDX_W-1:0]  last_idx;
  logic [STI_WORD_W-1:0] base;

  // The first bit of a frame takes its config live and starts from an empty register.
  always_comb begin
    len_eff  = start_i ? len_i : len_q;
    msb_eff  = start_i ? msb_i : msb_q;
    idx_eff  = start_i ? '0 : idx_q;
    base     = start_i ? '0 : sh_q;
    last_idx = STI_IDX_W'(sti_len_bits(len_eff) - 6'd1);

    if (msb_eff) begin
      word_c = {base[STI_WORD_W-2:0], bit_i};
    end else begin
      word_c          = base;
      word_c[idx_eff] = bit_i;
    end

    done_c = sample_i && (idx_eff == last_idx);

    idx_d = idx_q;
    sh_d  = sh_q;
    len_d = len_q;
    msb_d = msb_q;
    if (sample_i) begin
      len_d = len_eff;
      msb_d = msb_eff;
      sh_d  = word_c;
      idx_d = done_c ? '0 : idx_eff + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      sh_q  <= '0;
      len_q <= STI_LEN_8;
      msb_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
      len_q <= len_d;
      msb_q <= msb_d;
    end
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial receiver top: FSM, output word register, handshake and frame counter.
// Define STI_RX_ERR_EN to abort frames on gaps and drop frames on overflow with error pulses.
module sti_rx
  import sti_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  si_data,
  input  logic                  si_valid,
  input  logic [STI_LEN_W-1:0]  cfg_length,
  input  logic                  cfg_msb,
  output logic [STI_WORD_W-1:0] po_data,
  output logic                  po_valid,
  input  logic                  po_ready,
  output logic [STI_CNT_W-1:0]  frame_cnt,
  output logic                  err_gap,
  output logic                  err_ovf
);

  sti_state_e            state_q, state_d;
  logic [STI_WORD_W-1:0] po_data_q, po_data_d;
  logic                  po_valid_q, po_valid_d;
  logic [STI_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  err_gap_q, err_gap_d;
  logic                  err_ovf_q, err_ovf_d;

  logic                  done_c;
  logic [STI_WORD_W-1:0] word_c;
  logic                  hs;

  sti_rx_assemble u_assemble (
    .clk      (clk),
    .reset    (reset),
    .sample_i (si_valid),
    .start_i  (state_q == ST_IDLE),
    .bit_i    (si_data),
    .len_i    (cfg_length),
    .msb_i    (cfg_msb),
    .done_c   (done_c),
    .word_c   (word_c)
  );

  always_comb begin
    state_d     = state_q;
    po_data_d   = po_data_q;
    po_valid_d  = po_valid_q;
    frame_cnt_d = frame_cnt_q;
    err_gap_d   = 1'b0;
    err_ovf_d   = 1'b0;

    hs = po_valid_q && po_ready;
    if (hs) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      po_valid_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (si_valid) state_d = ST_RECV;
      end
      ST_RECV: begin
`ifdef STI_RX_ERR_EN
        if (!si_valid) begin
          state_d   = ST_IDLE;
          err_gap_d = 1'b1;
        end else if (done_c) begin
          state_d = ST_IDLE;
        end
`else
        if (done_c) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing frame loads unless the held word is still waiting.
    if (done_c) begin
      if (!po_valid_q || po_ready) begin
        po_data_d  = word_c;
        po_valid_d = 1'b1;
      end else begin
`ifdef STI_RX_ERR_EN
        err_ovf_d = 1'b1;
`else
        po_data_d = word_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      po_data_q   <= '0;
      po_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_gap_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      po_data_q   <= po_data_d;
      po_valid_q  <= po_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_gap_q   <= err_gap_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_valid  = po_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign err_gap   = err_gap_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for sti_rx; expectations follow STI_RX_ERR_EN when defined.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic [31:0] po_data;
  logic        po_valid;
  logic        po_ready;
  logic [15:0] frame_cnt;
  logic        err_gap;
  logic        err_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sti_rx dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .frame_cnt  (frame_cnt),
    .err_gap    (err_gap),
    .err_ovf    (err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then settle 1 time unit past the edge.
  task automatic step(input logic v, input logic d);
    si_valid = v;
    si_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits, input int first,
                           input int count, input logic msb);
    logic [31:0] w;
    w = val;
    for (int i = first; i < first + count; i++) begin
      if (msb) step(1'b1, w[5'(nbits - 1 - i)]);
      else     step(1'b1, w[5'(i)]);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    si_data    = 1'b0;
    si_valid   = 1'b0;
    cfg_length = 2'b00;
    cfg_msb    = 1'b0;
    po_ready   = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_valid", 32'(po_valid), 32'd0);
    chk("rst_data", po_data, 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_gap", 32'(err_gap), 32'd0);
    chk("rst_ovf", 32'(err_ovf), 32'd0);
    reset = 1'b0;

    // 16-bit MSB-first
    cfg_length = 2'b01; cfg_msb = 1'b1; po_ready = 1'b1;
    send_bits(32'h0000A5C3, 16, 0, 16, 1'b1);
    chk("m16_valid", 32'(po_valid), 32'd1);
    chk("m16_data", po_data, 32'h0000A5C3);
    chk("m16_cnt_pre", 32'(frame_cnt), 32'd0);
    step(1'b0, 1'b0);
    chk("m16_cnt", 32'(frame_cnt), 32'd1);
    chk("m16_valid_drop", 32'(po_valid), 32'd0);

    // 8-bit LSB-first back-to-back with 32-bit MSB-first
    cfg_length = 2'b00; cfg_msb = 1'b0;
    send_bits(32'h0000003C, 8, 0, 8, 1'b0);
    chk("l8_data", po_data, 32'h0000003C);
    chk("l8_valid", 32'(po_valid), 32'd1);
    cfg_length = 2'b11; cfg_msb = 1'b1;
    send_bits(32'hDEADBEEF, 32, 0, 32, 1'b1);
    chk("m32_data", po_data, 32'hDEADBEEF);
    chk("m32_cnt_pre", 32'(frame_cnt), 32'd2);
    step(1'b0, 1'b0);
    chk("m32_cnt", 32'(frame_cnt), 32'd3);

    // 24-bit frame with a one-cycle gap after 10 bits
    cfg_length = 2'b10; cfg_msb = 1'b1;
    send_bits(32'h00123456, 24, 0, 10, 1'b1);
    step(1'b0, 1'b0);
`ifdef STI_RX_ERR_EN
    chk("gap_pulse", 32'(err_gap), 32'd1);
`else
    chk("gap_pulse", 32'(err_gap), 32'd0);
`endif
    send_bits(32'h00123456, 24, 10, 14, 1'b1);
    chk("gap_pulse_end", 32'(err_gap), 32'd0);
`ifdef STI_RX_ERR_EN
    chk("gap_no_word", 32'(po_valid), 32'd0);
`else
    chk("gap_valid", 32'(po_valid), 32'd1);
    chk("gap_data", po_data, 32'h00123456);
`endif
    step(1'b0, 1'b0);
`ifdef STI_RX_ERR_EN
    chk("gap_cnt", 32'(frame_cnt), 32'd3);
`else
    chk("gap_cnt", 32'(frame_cnt), 32'd4);
`endif

    // Overflow while holding 0xAA
    apply_reset();
    po_ready = 1'b0; cfg_length = 2'b00; cfg_msb = 1'b1;
    send_bits(32'h000000AA, 8, 0, 8, 1'b1);
    chk("ovf_hold_data", po_data, 32'h000000AA);
    send_bits(32'h00000055, 8, 0, 8, 1'b1);
`ifdef STI_RX_ERR_EN
    chk("ovf_pulse", 32'(err_ovf), 32'd1);
    chk("ovf_data", po_data, 32'h000000AA);
`else
    chk("ovf_pulse", 32'(err_ovf), 32'd0);
    chk("ovf_data", po_data, 32'h00000055);
`endif
    chk("ovf_valid", 32'(po_valid), 32'd1);
    step(1'b0, 1'b0);
    chk("ovf_pulse_end", 32'(err_ovf), 32'd0);
    po_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("ovf_cnt", 32'(frame_cnt), 32'd1);
    chk("ovf_valid_drop", 32'(po_valid), 32'd0);

    // Completion on the same edge as the handshake
    apply_reset();
    po_ready = 1'b0;
    send_bits(32'h000000AA, 8, 0, 8, 1'b1);
    send_bits(32'h00000055, 8, 0, 7, 1'b1);
    po_ready = 1'b1;
    send_bits(32'h00000055, 8, 7, 1, 1'b1);
    chk("same_data", po_data, 32'h00000055);
    chk("same_valid", 32'(po_valid), 32'd1);
    chk("same_cnt1", 32'(frame_cnt), 32'd1);
    chk("same_ovf", 32'(err_ovf), 32'd0);
    step(1'b0, 1'b0);
    chk("same_cnt2", 32'(frame_cnt), 32'd2);

    // Reset in the middle of a 16-bit frame with a word held
    po_ready = 1'b0;
    send_bits(32'h000000AA, 8, 0, 8, 1'b1);
    cfg_length = 2'b01;
    send_bits(32'h0000FFFF, 16, 0, 5, 1'b1);
    reset = 1'b1;
    step(1'b1, 1'b1);
    chk("mid_rst_valid", 32'(po_valid), 32'd0);
    chk("mid_rst_data", po_data, 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_gap", 32'(err_gap), 32'd0);
    chk("mid_rst_ovf", 32'(err_ovf), 32'd0);
    reset = 1'b0; po_ready = 1'b1;
    send_bits(32'h00000F0F, 16, 0, 16, 1'b1);
    chk("post_rst_data", po_data, 32'h00000F0F);
    chk("post_rst_valid", 32'(po_valid), 32'd1);
    step(1'b0, 1'b0);

    // Frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_d;
    chk("wrap_pre", 32'(frame_cnt), 32'h0000FFFF);
    cfg_length = 2'b00;
    send_bits(32'h000000AA, 8, 0, 8, 1'b1);
    chk("wrap_hold", 32'(frame_cnt), 32'h0000FFFF);
    step(1'b0, 1'b0);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap_valid", 32'(po_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI serial stream: the far end of the link driven by the team's serial transmitter (so_data/so_valid). It samples the bit stream, reassembles frames of 8/16/24/32 bits in MSB-first or LSB-first order, and presents each frame as a right-aligned 32-bit word on a valid/ready output port. It sits between the serial link pins and the downstream word consumer, which is typically a memory writer.

## Interface
- No parameters. Frame widths are fixed by the length encoding.
- clk  input  1  Single system clock, rising edge.
- reset  input  1  Synchronous, active-high reset.
- si_data  input  1  Serial data bit, sampled when si_valid=1.
- si_valid  input  1  Serial bit-valid qualifier.
- cfg_length  input  2  Frame width: 00=8, 01=16, 10=24, 11=32 bits.
- cfg_msb  input  1  1 = first received bit is the frame MSB; 0 = first bit is the LSB.
- po_data  output  32  Assembled frame, right-aligned; unused upper bits are 0.
- po_valid  output  1  Word available on po_data.
- po_ready  input  1  Consumer accepts the word when po_valid && po_ready.
- frame_cnt  output  16  Count of words delivered (handshakes); wraps 0xFFFF→0x0000.
- err_gap  output  1  One-cycle pulse: frame aborted by a gap (only with STI_RX_ERR_EN).
- err_ovf  output  1  One-cycle pulse: frame dropped on overflow (only with STI_RX_ERR_EN).

## Operation
- States: IDLE, RECV.
- IDLE: the first cycle with si_valid=1 latches cfg_length and cfg_msb into frame registers, samples bit 0, and moves to RECV. Config changes during a frame are ignored.
- RECV: each si_valid=1 cycle samples one bit; bit counter runs 0..N-1 with N=8*(len+1).
- MSB-first: shift register shifts left, inserting at bit 0.
- LSB-first: bit k is written to position k.
- In both modes the result occupies bits [N-1:0].
- The N-th bit completes the frame. Assembled bits move to the output register and the FSM returns to IDLE. A bit arriving in the next cycle starts a new frame, so back-to-back frames need no idle cycle.
- Output register:
  - po_valid stays high until a handshake occurs.
  - po_data stays stable while po_valid=1 && po_ready=0.
  - frame_cnt increments on each handshake.
- Frame completes while po_valid=0, or in the same cycle as a handshake: the new word loads; no overflow.
- Frame completes while po_valid=1 && po_ready=0: overflow (behaviour set by Configuration).
- Gap (si_valid=0 while in RECV): behaviour set by Configuration.
- Reset, including mid-frame or mid-hold:
  - State goes to IDLE; bit counter cleared; the partial frame is discarded.
  - po_valid=0, po_data=0, frame_cnt=0, err_gap=0, err_ovf=0.

## Timing
- Latency: last bit sampled at edge t; po_valid=1 and po_data valid immediately after edge t.
- Handshake is evaluated at the rising edge. po_valid falls after the accepting edge unless a new frame completes at that same edge.
- err_gap and err_ovf are high for exactly one cycle, following the edge that detected the event.
- Maximum sustained rate: one bit per cycle; one word per N cycles.

## Configuration
- Macro: STI_RX_ERR_EN.
- Defined, gap: the partial frame is discarded, err_gap pulses, FSM goes to IDLE. The next si_valid=1 starts a fresh frame.
- Defined, overflow: the completed frame is dropped, the held word is preserved, and err_ovf pulses.
- Undefined, gap: the gap is tolerated; the receiver holds its state and resumes at the next si_valid=1.
- Undefined, overflow: the new frame overwrites po_data; po_valid stays high.
- Undefined: err_gap and err_ovf are tied to 0.

## Structure
- Package sti_pkg:
  - length encoding constants (STI_LEN_8/16/24/32);
  - a function converting the length code to a bit count;
  - the FSM state enum.
- Sub-module sti_rx_assemble: bit counter and shift/position register, signalling frame done. The top level holds the FSM, output register, handshake, counter and error logic.

## Test plan
- 16-bit MSB-first (cfg_length=01, cfg_msb=1), bits of 0xA5C3 sent MSB first, continuous valid, po_ready=1 → po_data=0x0000A5C3 after the 16th bit edge, frame_cnt=1.
- 8-bit LSB-first (00, msb=0), bits 0,0,1,1,1,1,0,0 → po_data=0x0000003C. Back-to-back with a 32-bit MSB-first frame 0xDEADBEEF → second word 0xDEADBEEF, no idle cycle needed.
- 24-bit 0x123456, then si_valid=0 after 10 bits, then 14 more bits:
  - ERR_EN → err_gap pulse and no word from the aborted frame;
  - no ERR_EN → po_data=0x00123456.
- po_ready=0 holding 0x000000AA, then a second 8-bit frame 0x55 completes:
  - ERR_EN → err_ovf pulse, po_data stays 0xAA;
  - no ERR_EN → po_data=0x55.
  - Repeat with po_ready=1 on the completion edge → both words delivered, frame_cnt=2.
- Reset asserted mid-frame (bit 5 of 16) → all outputs 0 next cycle. A following full 16-bit 0x0F0F frame → 0x00000F0F.
- Force frame_cnt to 0xFFFF, then one handshake → frame_cnt=0x0000.
